// File: rtl/run_length_meter_if.sv
// Result handshake between run_length_meter (master) and its consumer (slave):
// a single-entry valid/ready register carrying one completed run length.
interface run_length_meter_if #(
   parameter int LEN_W = 8
);
   logic             len_valid;
   logic             len_ready;
   logic [LEN_W-1:0] len_data;

   modport master (output len_valid, output len_data, input len_ready);
   modport slave  (input len_valid, input len_data, output len_ready);
endinterface

// File: rtl/run_length_meter.sv
// Measures the length of every high run on det_in and presents it on a one-entry
// valid/ready register; counts completed runs. Optional: RLM_DROP_CNT_EN adds drop_count.
module run_length_meter #(
   parameter int LEN_W = 8,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    det_in,
   input  logic                    clr,
   run_length_meter_if.master      len,
   output logic [CNT_W-1:0]        evt_count,
`ifdef RLM_DROP_CNT_EN
   output logic [CNT_W-1:0]        drop_count,
`endif
   output logic                    busy
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
   logic             run_end;
   logic             slot_free;

   assign run_end   = (state_q == RUN) && !det_in;
   assign slot_free = !len.len_valid || len.len_ready;
   assign busy      = (state_q == RUN);

   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      case (state_q)
         IDLE: begin
            if (det_in) begin
               state_d   = RUN;
               run_cnt_d = {{(LEN_W-1){1'b0}}, 1'b1};
            end
         end
         RUN: begin
            if (det_in) begin
               if (run_cnt_q != LEN_MAX) run_cnt_d = run_cnt_q + 1'b1;
            end else begin
               state_d   = IDLE;
               run_cnt_d = '0;
            end
         end
         default: begin
            state_d   = IDLE;
            run_cnt_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         run_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
      end
   end

   // A run end reloads the slot even in the cycle the previous result is accepted.
   always_ff @(posedge clk) begin
      if (!reset) begin
         len.len_valid <= 1'b0;
         len.len_data  <= '0;
      end else if (run_end && slot_free) begin
         len.len_valid <= 1'b1;
         len.len_data  <= run_cnt_q;
      end else if (len.len_valid && len.len_ready) begin
         len.len_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         evt_count <= '0;
      end else if (run_end && evt_count != CNT_MAX) begin
         evt_count <= evt_count + 1'b1;
      end
   end

`ifdef RLM_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         drop_count <= '0;
      end else if (run_end && !slot_free && drop_count != CNT_MAX) begin
         drop_count <= drop_count + 1'b1;
      end
   end
`endif

endmodule
